// File: rtl/vctrl_pkg.sv
// Shared types and register indices for the vector control write sequencer.
package vctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_M31,
      S_WR_M30,
      S_WR_M29,
      S_WR_VL,
      S_STRIP
   } state_t;

   localparam int VL_REG         = 0;
   localparam int MASK_AROWS_REG = 31;
   localparam int MASK_ACOLS_REG = 30;
   localparam int MASK_BCOLS_REG = 29;

   localparam int MASK_W_DEF     = 8;
   localparam int MASK_CW_DEF    = 4;

endpackage

// File: rtl/count_to_mask.sv
// Count to saturating thermometer mask: low i_cnt bits set, capped at MMS.
module count_to_mask #(
   parameter int MMS = 8,
   parameter int CW  = 4
) (
   input  logic [CW-1:0]  i_cnt,
   output logic [MMS-1:0] o_mask
);

   always_comb begin
      o_mask = '0;
      for (int i = 0; i < MMS; i++) begin
         o_mask[i] = ($unsigned(i) < 32'(i_cnt));
      end
   end

endmodule

// File: rtl/vctrl_stripmine_seq.sv
// Strip-mining writer for the vector control register file.
// Optional VCTRL_SEQ_MASK_SKIP_EN: skip mask writes that match a shadow copy.
module vctrl_stripmine_seq
   import vctrl_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int LOG2NUMREGS  = 5,
   parameter int MVL          = 64,
   parameter int MAT_MUL_SIZE = MASK_W_DEF,
   parameter int CW           = MASK_CW_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [WIDTH-1:0]       req_total,
   input  logic [CW-1:0]          req_a_rows,
   input  logic [CW-1:0]          req_a_cols,
   input  logic [CW-1:0]          req_b_cols,
   output logic [LOG2NUMREGS-1:0] c_reg,
   output logic [WIDTH-1:0]       c_writedatain,
   output logic                   c_we,
   output logic                   strip_valid,
   output logic [WIDTH-1:0]       strip_vl,
   output logic                   strip_last,
   input  logic                   strip_next,
   output logic                   busy
);

   state_t                  r_state;
   state_t                  w_next;
   logic [WIDTH-1:0]        r_remaining;
   logic [CW-1:0]           r_arows;
   logic [CW-1:0]           r_acols;
   logic [CW-1:0]           r_bcols;

   logic                    w_accept;
   logic                    w_idle;
   logic [CW-1:0]           w_arows;
   logic [CW-1:0]           w_acols;
   logic [CW-1:0]           w_bcols;
   logic [CW-1:0]           w_cnt;
   logic [MAT_MUL_SIZE-1:0] w_mask;
   logic [WIDTH-1:0]        w_rem;
   logic [WIDTH-1:0]        w_vl;
   logic                    w_need31;
   logic                    w_need30;
   logic                    w_need29;
   state_t                  w_from29;
   state_t                  w_from30;
   state_t                  w_from31;

   assign w_accept = req_valid && req_ready;
   assign w_idle   = (r_state == S_IDLE);

   // In IDLE the latched copies are stale, so look at the request directly
   assign w_arows = w_idle ? req_a_rows : r_arows;
   assign w_acols = w_idle ? req_a_cols : r_acols;
   assign w_bcols = w_idle ? req_b_cols : r_bcols;
   assign w_rem   = w_idle ? req_total  : r_remaining;

   assign w_vl = (w_rem >= WIDTH'(MVL)) ? WIDTH'(MVL) : w_rem;

   always_comb begin
      w_cnt = w_bcols;
      if (w_next == S_WR_M31) w_cnt = w_arows;
      if (w_next == S_WR_M30) w_cnt = w_acols;
   end

   count_to_mask #(.MMS(MAT_MUL_SIZE), .CW(CW)) u_mask (
      .i_cnt  (w_cnt),
      .o_mask (w_mask)
   );

`ifdef VCTRL_SEQ_MASK_SKIP_EN
   logic [MAT_MUL_SIZE-1:0] r_sh31;
   logic [MAT_MUL_SIZE-1:0] r_sh30;
   logic [MAT_MUL_SIZE-1:0] r_sh29;
   logic [MAT_MUL_SIZE-1:0] w_m31;
   logic [MAT_MUL_SIZE-1:0] w_m30;
   logic [MAT_MUL_SIZE-1:0] w_m29;

   count_to_mask #(.MMS(MAT_MUL_SIZE), .CW(CW)) u_m31 (
      .i_cnt (w_arows), .o_mask (w_m31));
   count_to_mask #(.MMS(MAT_MUL_SIZE), .CW(CW)) u_m30 (
      .i_cnt (w_acols), .o_mask (w_m30));
   count_to_mask #(.MMS(MAT_MUL_SIZE), .CW(CW)) u_m29 (
      .i_cnt (w_bcols), .o_mask (w_m29));

   assign w_need31 = (w_m31 != r_sh31);
   assign w_need30 = (w_m30 != r_sh30);
   assign w_need29 = (w_m29 != r_sh29);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sh31 <= '1;
         r_sh30 <= '1;
         r_sh29 <= '1;
      end else begin
         if (w_next == S_WR_M31) r_sh31 <= w_mask;
         if (w_next == S_WR_M30) r_sh30 <= w_mask;
         if (w_next == S_WR_M29) r_sh29 <= w_mask;
      end
   end
`else
   assign w_need31 = 1'b1;
   assign w_need30 = 1'b1;
   assign w_need29 = 1'b1;
`endif

   assign w_from29 = w_need29 ? S_WR_M29 : S_WR_VL;
   assign w_from30 = w_need30 ? S_WR_M30 : w_from29;
   assign w_from31 = w_need31 ? S_WR_M31 : w_from30;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = w_from31;
         S_WR_M31: w_next = w_from30;
         S_WR_M30: w_next = w_from29;
         S_WR_M29: w_next = S_WR_VL;
         // A zero vl only happens for an empty job
         S_WR_VL:  w_next = (strip_vl == '0) ? S_IDLE : S_STRIP;
         S_STRIP: begin
            if (strip_next) w_next = strip_last ? S_IDLE : S_WR_VL;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the state being entered
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         req_ready     <= 1'b1;
         busy          <= 1'b0;
         c_we          <= 1'b0;
         c_reg         <= '0;
         c_writedatain <= '0;
         strip_valid   <= 1'b0;
         strip_vl      <= '0;
         strip_last    <= 1'b0;
         r_remaining   <= '0;
         r_arows       <= '0;
         r_acols       <= '0;
         r_bcols       <= '0;
      end else begin
         r_state     <= w_next;
         req_ready   <= (w_next == S_IDLE);
         busy        <= (w_next != S_IDLE);
         strip_valid <= (w_next == S_STRIP);
         c_we        <= 1'b0;
         if (w_accept) begin
            r_remaining <= req_total;
            r_arows     <= req_a_rows;
            r_acols     <= req_a_cols;
            r_bcols     <= req_b_cols;
         end
         case (w_next)
            S_WR_M31: begin
               c_we          <= 1'b1;
               c_reg         <= LOG2NUMREGS'(MASK_AROWS_REG);
               c_writedatain <= WIDTH'(w_mask);
            end
            S_WR_M30: begin
               c_we          <= 1'b1;
               c_reg         <= LOG2NUMREGS'(MASK_ACOLS_REG);
               c_writedatain <= WIDTH'(w_mask);
            end
            S_WR_M29: begin
               c_we          <= 1'b1;
               c_reg         <= LOG2NUMREGS'(MASK_BCOLS_REG);
               c_writedatain <= WIDTH'(w_mask);
            end
            S_WR_VL: begin
               c_we          <= 1'b1;
               c_reg         <= LOG2NUMREGS'(VL_REG);
               c_writedatain <= w_vl;
               r_remaining   <= w_rem - w_vl;
               strip_vl      <= w_vl;
               strip_last    <= (w_rem == w_vl);
            end
            default: ;
         endcase
      end
   end

endmodule
